// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder/scan family.
//
// Contents:
//   state_t        FSM states for the scanning decoder (IDLE, DIRECT, SCAN, BLANK)
//   MAX_OUT_W      widest decoded vector the helpers support
//   onehot_low()   active-low one-hot vector for a given index and width
//   cnt_width()    dwell/blank counter width: clog2(max(dwell, blank, 2))
//   CNT_W_DEFAULT  counter width for the default DWELL=4, BLANK_CYC=1
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN,
        BLANK
    } state_t;

    localparam int MAX_OUT_W = 256;

    // Bits at or above 'width' stay high, so callers may truncate freely.
    function automatic logic [MAX_OUT_W-1:0] onehot_low(input int index, input int width);
        logic [MAX_OUT_W-1:0] v;
        v = '1;
        if (index >= 0 && index < width && index < MAX_OUT_W) begin
            v[index[7:0]] = 1'b0;
        end
        return v;
    endfunction

    // One counter serves both the dwell and the blank phases, so it is sized
    // for whichever is longer (never narrower than one bit).
    function automatic int cnt_width(input int dwell, input int blank);
        int m;
        m = 2;
        if (dwell > m) begin
            m = dwell;
        end
        if (blank > m) begin
            m = blank;
        end
        return $clog2(m);
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(4, 1);

endpackage

// File: rtl/decoder_core.sv
// Purely combinational N-to-2^N decoder with active-low outputs.
//
// Ports:
//   enable_n  in   active-low enable; high drives every output high
//   sel       in   SEL_W-bit index to decode
//   out       out  2**SEL_W active-low one-hot outputs
module decoder_core
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic                 enable_n,
    input  logic [SEL_W-1:0]     sel,
    output logic [2**SEL_W-1:0]  out
);

    localparam int OUT_W = 2**SEL_W;

    always_comb begin
        out = '1;
        if (!enable_n) begin
            out = OUT_W'(onehot_low(int'(sel), OUT_W));
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N decoder with active-low one-hot outputs, plus an
// auto-scan mode that walks outputs 0..NUM_OUT-1 with a dwell time and an
// optional all-off blanking gap between steps.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable_n  in   active-low enable; high forces all outputs inactive
//   mode      in   0 = direct decode of sel, 1 = auto-scan
//   sel       in   select index (direct mode only)
//   out       out  registered active-low one-hot outputs
//   idx       out  index currently or last driven
//   active    out  high when exactly one out bit is low
//   wrap      out  one-cycle pulse when the scan returns to index 0
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int NUM_OUT   = 2**SEL_W,
    parameter int DWELL     = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [2**SEL_W-1:0]  out,
    output logic [SEL_W-1:0]     idx,
    output logic                 active,
    output logic                 wrap
);

    localparam int OUT_W = 2**SEL_W;
    localparam int CNT_W = cnt_width(DWELL, BLANK_CYC);

    localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_OUT - 1);
    // One extra bit so NUM_OUT == 2**SEL_W is representable in the range check.
    localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);

    state_t            state;
    state_t            nxt_state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [SEL_W-1:0]  nxt_idx;
    logic [SEL_W-1:0]  idx_adv;
    logic              nxt_show;
    logic              nxt_wrap;
    logic              dec_en_n;
    logic [OUT_W-1:0]  dec_out;

    assign idx_adv = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    // Next-cycle state and what the out register should show. Priority is
    // enable_n, then mode; the counter defaults to cleared so every exit from
    // a dwell or blank phase restarts timing from zero.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        nxt_idx   = idx;
        nxt_show  = 1'b0;
        nxt_wrap  = 1'b0;
        if (enable_n) begin
            nxt_state = IDLE;
        end else if (!mode) begin
            nxt_state = DIRECT;
            if ({1'b0, sel} < NUM_OUT_EXT) begin
                nxt_idx  = sel;
                nxt_show = 1'b1;
            end
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == DWELL_LAST) begin
                        if (BLANK_CYC > 0) begin
                            nxt_state = BLANK;
                        end else begin
                            nxt_state = SCAN;
                            nxt_idx   = idx_adv;
                            nxt_show  = 1'b1;
                            nxt_wrap  = (idx_adv == '0);
                        end
                    end else begin
                        nxt_state = SCAN;
                        nxt_cnt   = cnt + 1'b1;
                        nxt_show  = 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = SCAN;
                        nxt_idx   = idx_adv;
                        nxt_show  = 1'b1;
                        nxt_wrap  = (idx_adv == '0);
                    end else begin
                        nxt_state = BLANK;
                        nxt_cnt   = cnt + 1'b1;
                    end
                end
                // Entering scan from IDLE or DIRECT always starts at index 0
                // with no leading blank.
                default: begin
                    nxt_state = SCAN;
                    nxt_idx   = '0;
                    nxt_show  = 1'b1;
                end
            endcase
        end
    end

    assign dec_en_n = ~nxt_show;

    decoder_core #(
        .SEL_W (SEL_W)
    ) u_core (
        .enable_n (dec_en_n),
        .sel      (nxt_idx),
        .out      (dec_out)
    );

    // Since the decoder is fed a single index, out can never have more than
    // one bit low, whatever transition is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            out    <= '1;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            idx    <= nxt_idx;
            out    <= dec_out;
            active <= nxt_show;
            wrap   <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan. Two instances share inputs:
//   dut0: SEL_W=2, NUM_OUT=4, DWELL=2, BLANK_CYC=1
//   dut1: SEL_W=2, NUM_OUT=3, DWELL=3, BLANK_CYC=0
// Expected values come from a reference model that derives scan position
// from the elapsed cycle count since scanning began.
module tb_decoder_scan;

    localparam int N0 = 4;
    localparam int D0 = 2;
    localparam int B0 = 1;
    localparam int N1 = 3;
    localparam int D1 = 3;
    localparam int B1 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_n = 1'b1;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [3:0]  out0;
    logic [3:0]  out1;
    logic [1:0]  idx0;
    logic [1:0]  idx1;
    logic        active0;
    logic        active1;
    logic        wrap0;
    logic        wrap1;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    decoder_scan #(
        .SEL_W(2), .NUM_OUT(N0), .DWELL(D0), .BLANK_CYC(B0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .mode(mode), .sel(sel),
        .out(out0), .idx(idx0), .active(active0), .wrap(wrap0)
    );

    decoder_scan #(
        .SEL_W(2), .NUM_OUT(N1), .DWELL(D1), .BLANK_CYC(B1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .mode(mode), .sel(sel),
        .out(out1), .idx(idx1), .active(active1), .wrap(wrap1)
    );

    typedef struct {
        bit          scanning;
        int          t;
        logic [1:0]  idx;
        logic [3:0]  out;
        logic        act;
        logic        wrap;
    } model_t;

    model_t m0;
    model_t m1;

    function automatic model_t model_reset();
        model_t r;
        r.scanning = 1'b0;
        r.t        = 0;
        r.idx      = 2'd0;
        r.out      = 4'hF;
        r.act      = 1'b0;
        r.wrap     = 1'b0;
        return r;
    endfunction

    // Scan position is pure arithmetic on t: step = t / period, phase = t % period.
    function automatic model_t model_step(model_t cur, int n, int d, int b,
                                          logic en_n, logic md, logic [1:0] s);
        model_t nx;
        int step;
        int pos;
        nx = cur;
        nx.wrap = 1'b0;
        if (en_n) begin
            nx.scanning = 1'b0;
            nx.t        = 0;
            nx.out      = 4'hF;
            nx.act      = 1'b0;
        end else if (!md) begin
            nx.scanning = 1'b0;
            nx.t        = 0;
            if (int'(s) < n) begin
                nx.out = ~(4'b0001 << s);
                nx.idx = s;
                nx.act = 1'b1;
            end else begin
                nx.out = 4'hF;
                nx.act = 1'b0;
            end
        end else begin
            nx.t        = cur.scanning ? cur.t + 1 : 0;
            nx.scanning = 1'b1;
            step        = nx.t / (d + b);
            pos         = nx.t % (d + b);
            nx.idx      = 2'(step % n);
            nx.act      = (pos < d);
            nx.out      = nx.act ? ~(4'b0001 << nx.idx) : 4'hF;
            nx.wrap     = (pos == 0) && (step % n == 0) && (nx.t > 0);
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= model_step(m0, N0, D0, B0, enable_n, mode, sel);
            m1 <= model_step(m1, N1, D1, B1, enable_n, mode, sel);
        end
    end

    task automatic apply_stimulus(input logic en_n, input logic md, input logic [1:0] s);
        enable_n = en_n;
        mode     = md;
        sel      = s;
    endtask

    task automatic go_idle();
        apply_stimulus(1'b1, 1'b0, 2'd0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b1, 2'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (out0 !== 4'hF) $display("[TB] FAIL reset_out0 got %b want 1111", out0); else n_pass++;
        n_checks++;
        if (idx0 !== 2'd0) $display("[TB] FAIL reset_idx0 got %0d want 0", idx0); else n_pass++;
        n_checks++;
        if (active0 !== 1'b0 || wrap0 !== 1'b0)
            $display("[TB] FAIL reset_flags0 got active=%b wrap=%b want 0 0", active0, wrap0);
        else n_pass++;
        n_checks++;
        if (out1 !== 4'hF) $display("[TB] FAIL reset_out1 got %b want 1111", out1); else n_pass++;
        // Release between edges: nothing may change until the next rising edge.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (out0 !== 4'hF) $display("[TB] FAIL reset_release_glitch got %b want 1111", out0); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'hF) $display("[TB] FAIL reset_release_hold got %b want 1111", out0); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1110) $display("[TB] FAIL reset_first_scan got %b want 1110", out0); else n_pass++;
    endtask

    task automatic test_direct();
        logic [1:0] sel_tab  [3] = '{2'd0, 2'd1, 2'd3};
        logic [3:0] exp0_tab [3] = '{4'b1110, 4'b1101, 4'b0111};
        logic [3:0] exp1_tab [3] = '{4'b1110, 4'b1101, 4'b1111};
        logic       act1_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0] idx1_tab [3] = '{2'd0, 2'd1, 2'd1};
        logic [3:0] prev_exp;
        go_idle();
        apply_stimulus(1'b0, 1'b0, 2'd2);
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1011 || idx0 !== 2'd2 || active0 !== 1'b1)
            $display("[TB] FAIL direct_sel2 got out=%b idx=%0d act=%b want 1011 2 1", out0, idx0, active0);
        else n_pass++;
        n_checks++;
        if (out1 !== 4'b1011) $display("[TB] FAIL direct_sel2_n3 got %b want 1011", out1); else n_pass++;
        prev_exp = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, sel_tab[i]);
            #1;
            n_checks++;
            if (out0 !== prev_exp)
                $display("[TB] FAIL direct_latency[%0d] got %b want %b", i, out0, prev_exp);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (out0 !== exp0_tab[i] || idx0 !== sel_tab[i])
                $display("[TB] FAIL direct_step0[%0d] got out=%b idx=%0d want %b %0d",
                         i, out0, idx0, exp0_tab[i], sel_tab[i]);
            else n_pass++;
            n_checks++;
            if (out1 !== exp1_tab[i] || active1 !== act1_tab[i] || idx1 !== idx1_tab[i])
                $display("[TB] FAIL direct_step1[%0d] got out=%b act=%b idx=%0d want %b %b %0d",
                         i, out1, active1, idx1, exp1_tab[i], act1_tab[i], idx1_tab[i]);
            else n_pass++;
            prev_exp = exp0_tab[i];
        end
    endtask

    task automatic test_scan_pattern();
        logic [3:0] pat [12] = '{4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1111,
                                 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b1111};
        int wraps;
        wraps = 0;
        go_idle();
        apply_stimulus(1'b0, 1'b1, 2'd0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (wrap0 === 1'b1 && c <= 12) wraps++;
            n_checks++;
            if (out0 !== pat[c % 12] || wrap0 !== (c % 12 == 0 && c > 0))
                $display("[TB] FAIL scan_pattern[%0d] got out=%b wrap=%b want %b %b",
                         c, out0, wrap0, pat[c % 12], (c % 12 == 0 && c > 0));
            else n_pass++;
            n_checks++;
            if ({out1, idx1, active1, wrap1} !== {m1.out, m1.idx, m1.act, m1.wrap} || idx1 === 2'd3)
                $display("[TB] FAIL scan_model1[%0d] got %b/%0d/%b/%b want %b/%0d/%b/%b", c,
                         out1, idx1, active1, wrap1, m1.out, m1.idx, m1.act, m1.wrap);
            else n_pass++;
        end
        n_checks++;
        if (wraps !== 1) $display("[TB] FAIL scan_wrap_count got %0d want 1", wraps); else n_pass++;
    endtask

    task automatic test_range();
        logic [3:0] pat1 [9] = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101,
                                 4'b1011, 4'b1011, 4'b1011};
        logic [3:0] visited;
        visited = 4'b0000;
        go_idle();
        apply_stimulus(1'b0, 1'b1, 2'd0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            visited[idx1] = 1'b1;
            n_checks++;
            if (out1 !== pat1[c % 9] || wrap1 !== (c % 9 == 0 && c > 0))
                $display("[TB] FAIL range_pattern[%0d] got out=%b wrap=%b want %b %b",
                         c, out1, wrap1, pat1[c % 9], (c % 9 == 0 && c > 0));
            else n_pass++;
        end
        n_checks++;
        if (visited !== 4'b0111) $display("[TB] FAIL range_visited got %b want 0111", visited); else n_pass++;
    endtask

    task automatic test_interrupt();
        go_idle();
        apply_stimulus(1'b0, 1'b1, 2'd0);
        repeat (7) @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1011 || idx0 !== 2'd2)
            $display("[TB] FAIL interrupt_pre got out=%b idx=%0d want 1011 2", out0, idx0);
        else n_pass++;
        apply_stimulus(1'b1, 1'b1, 2'd0);
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'hF || active0 !== 1'b0 || wrap0 !== 1'b0)
            $display("[TB] FAIL interrupt_off got out=%b act=%b wrap=%b want 1111 0 0", out0, active0, wrap0);
        else n_pass++;
        apply_stimulus(1'b0, 1'b1, 2'd0);
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1110 || idx0 !== 2'd0 || wrap0 !== 1'b0)
            $display("[TB] FAIL interrupt_restart got out=%b idx=%0d wrap=%b want 1110 0 0", out0, idx0, wrap0);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        logic [3:0] after [3] = '{4'b1110, 4'b1110, 4'b1111};
        go_idle();
        apply_stimulus(1'b0, 1'b1, 2'd1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (out0 !== 4'hF || active0 !== 1'b0)
            $display("[TB] FAIL mode_blank got out=%b act=%b want 1111 0", out0, active0);
        else n_pass++;
        apply_stimulus(1'b0, 1'b0, 2'd1);
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1101 || idx0 !== 2'd1 || active0 !== 1'b1)
            $display("[TB] FAIL mode_to_direct got out=%b idx=%0d act=%b want 1101 1 1", out0, idx0, active0);
        else n_pass++;
        apply_stimulus(1'b0, 1'b1, 2'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out0 !== after[c])
                $display("[TB] FAIL mode_to_scan[%0d] got %b want %b", c, out0, after[c]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic md;
        md = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) md = ~md;
            apply_stimulus(($urandom_range(0, 15) == 0), md, 2'($urandom_range(0, 3)));
            @(negedge clk);
            n_checks++;
            if ({out0, idx0, active0, wrap0} !== {m0.out, m0.idx, m0.act, m0.wrap})
                $display("[TB] FAIL random0[%0d] got %b/%0d/%b/%b want %b/%0d/%b/%b", c,
                         out0, idx0, active0, wrap0, m0.out, m0.idx, m0.act, m0.wrap);
            else n_pass++;
            n_checks++;
            if ({out1, idx1, active1, wrap1} !== {m1.out, m1.idx, m1.act, m1.wrap})
                $display("[TB] FAIL random1[%0d] got %b/%0d/%b/%b want %b/%0d/%b/%b", c,
                         out1, idx1, active1, wrap1, m1.out, m1.idx, m1.act, m1.wrap);
            else n_pass++;
            n_checks++;
            if ($countones(~out0) > 1 || $countones(~out1) > 1)
                $display("[TB] FAIL random_onehot[%0d] got %b %b want at most one low bit", c, out0, out1);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        apply_stimulus(1'b0, 1'b1, 2'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out0 !== 4'hF || idx0 !== 2'd0 || active0 !== 1'b0)
            $display("[TB] FAIL async_reset0 got out=%b idx=%0d act=%b want 1111 0 0", out0, idx0, active0);
        else n_pass++;
        n_checks++;
        if (out1 !== 4'hF) $display("[TB] FAIL async_reset1 got %b want 1111", out1); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out0 !== 4'b1110 || {out0, idx0, active0, wrap0} !== {m0.out, m0.idx, m0.act, m0.wrap})
            $display("[TB] FAIL async_reset_resume got %b want 1110", out0);
        else n_pass++;
    endtask

    initial begin
        $display("[TB] decoder_scan bench starting");
        test_reset();
        test_direct();
        test_scan_pattern();
        test_range();
        test_interrupt();
        test_mode_switch();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
